// File: rtl/cd101_pkg.sv
// rtl/cd101_pkg.sv - shared constants and FSM state type for the SPI configuration controller
//
// Purpose: register address width, auto-increment flag position, bank size
// limit and the frame decoder state enum.
// Ports: none (package).
package cd101_pkg;

  localparam int CFG_ADDR_W  = 7;
  localparam int CFG_INC_BIT = 7;
  localparam int NREGS_MAX   = 128;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ADDR,
    DATA
  } cfg_state_e;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-FF synchroniser with history flop and edge detection
//
// Purpose: brings one asynchronous level into the clk domain and flags its edges.
// Ports:
//   clk   in   system clock
//   rstn  in   synchronous active-low reset (all flops load RST_VAL)
//   din   in   raw asynchronous input
//   level out  synchronised level
//   rise  out  synchronised level went 0 -> 1 this cycle
//   fall  out  synchronised level went 1 -> 0 this cycle
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic hist;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      hist <= RST_VAL;
    end else begin
      s1   <= din;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~hist;
  assign fall  = ~s2 & hist;

endmodule

// File: rtl/spi_cfg_ctrl.sv
// rtl/spi_cfg_ctrl.sv - SPI-slave write-only configuration controller with shadow/active banks
//
// Purpose: decodes frames of (address byte, data bytes...) from an asynchronous
// mode-0 SPI master into a shadow register bank and commits the shadow bank to
// the active bank atomically when the frame ends.
// Ports:
//   clk       in   system clock
//   rstn      in   synchronous active-low reset
//   spi_clk   in   raw SPI clock (async)
//   spi_mosi  in   raw SPI data, MSB first (async)
//   spi_nss   in   raw SPI select, active-low (async)
//   regs_q    out  active bank, register i at [8i+7:8i]
//   commit    out  1-cycle pulse when regs_q takes the shadow bank
//   wr_strobe out  1-cycle pulse per in-range data byte written
//   wr_addr   out  address of the latest wr_strobe
//   busy      out  frame in progress
module spi_cfg_ctrl
  import cd101_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_nss,
  output logic [NREGS*8-1:0]    regs_q,
  output logic                  commit,
  output logic                  wr_strobe,
  output logic [CFG_ADDR_W-1:0] wr_addr,
  output logic                  busy
);

  logic sck_level, sck_rise, sck_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic nss_level, nss_rise, nss_fall;

  sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rstn(rstn), .din(spi_clk),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rstn(rstn), .din(spi_mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_sync_nss (
    .clk(clk), .rstn(rstn), .din(spi_nss),
    .level(nss_level), .rise(nss_rise), .fall(nss_fall)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, sck_level, sck_fall, mosi_rise, mosi_fall};

  cfg_state_e            state;
  cfg_state_e            state_d;
  logic [2:0]            bit_cnt;
  logic [6:0]            shift_q;
  logic [CFG_ADDR_W-1:0] addr_q;
  logic                  inc_q;
  logic                  dirty;
  logic [1:0]            settle_cnt;
  logic [NREGS*8-1:0]    shadow;

  logic       frame_start;
  logic       frame_end;
  logic       shift_en;
  logic       addr_done;
  logic       data_done;
  logic       addr_hit;
  logic [7:0] byte_w;

  // The byte being completed: seven bits already shifted plus the bit
  // sampled on this spi_clk rise.
  assign byte_w   = {shift_q, mosi_level};
  assign addr_hit = int'(addr_q) < NREGS;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // The nss synchroniser resets to 1, so its level is not trustworthy until
  // it has been refilled from the pin; settle_cnt holds WAIT_IDLE long enough
  // that a frame already running at reset release is never mistaken for idle.
  always_comb begin
    state_d     = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    shift_en    = 1'b0;
    addr_done   = 1'b0;
    data_done   = 1'b0;
    unique case (state)
      WAIT_IDLE: begin
        if (settle_cnt == 2'd3 && nss_level) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (nss_fall) begin
          frame_start = 1'b1;
          state_d     = ADDR;
        end
      end
      ADDR, DATA: begin
        // nss rising wins over a simultaneous spi_clk rise.
        if (nss_rise) begin
          frame_end = 1'b1;
          state_d   = IDLE;
        end else if (sck_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            if (state == ADDR) begin
              addr_done = 1'b1;
              state_d   = DATA;
            end else begin
              data_done = 1'b1;
            end
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      settle_cnt <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      inc_q      <= 1'b0;
      dirty      <= 1'b0;
      shadow     <= '0;
      regs_q     <= '0;
      commit     <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      busy       <= 1'b0;
    end else begin
      commit    <= 1'b0;
      wr_strobe <= 1'b0;

      if (state == WAIT_IDLE && settle_cnt != 2'd3) begin
        settle_cnt <= settle_cnt + 2'd1;
      end

      if (frame_start) begin
        busy    <= 1'b1;
        bit_cnt <= '0;
        dirty   <= 1'b0;
      end

      if (frame_end) begin
        busy    <= 1'b0;
        bit_cnt <= '0;
        dirty   <= 1'b0;
        if (dirty) begin
          regs_q <= shadow;
          commit <= 1'b1;
        end
      end

      // bit_cnt wraps 7 -> 0, so it is ready for the next byte on its own.
      if (shift_en) begin
        shift_q <= byte_w[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (addr_done) begin
        addr_q <= byte_w[CFG_ADDR_W-1:0];
        inc_q  <= byte_w[CFG_INC_BIT];
      end

      if (data_done) begin
        if (addr_hit) begin
          wr_strobe <= 1'b1;
          wr_addr   <= addr_q;
          dirty     <= 1'b1;
        end
        if (inc_q) begin
          addr_q <= addr_q + 7'd1;
        end
      end

      for (int i = 0; i < NREGS; i++) begin
        if (data_done && addr_hit && addr_q == 7'(i)) begin
          shadow[i*8 +: 8] <= byte_w;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// tb/tb_spi_cfg_ctrl.sv - self-checking bench for spi_cfg_ctrl with a frame-level reference model
module tb_spi_cfg_ctrl;

  localparam int NREGS = 8;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 spi_clk = 1'b0;
  logic                 spi_mosi = 1'b0;
  logic                 spi_nss = 1'b1;
  logic [NREGS*8-1:0]   regs_q;
  logic                 commit;
  logic                 wr_strobe;
  logic [6:0]           wr_addr;
  logic                 busy;

  spi_cfg_ctrl #(.NREGS(NREGS)) dut (
    .clk(clk),
    .rstn(rstn),
    .spi_clk(spi_clk),
    .spi_mosi(spi_mosi),
    .spi_nss(spi_nss),
    .regs_q(regs_q),
    .commit(commit),
    .wr_strobe(wr_strobe),
    .wr_addr(wr_addr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observation of the output pulses, sampled mid-cycle.
  int obs_addr[$];
  int commit_cycles = 0;
  bit busy_seen = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (wr_strobe) obs_addr.push_back(int'(wr_addr));
      if (commit) commit_cycles++;
      if (busy) busy_seen = 1'b1;
    end
  end

  // Reference model: shadow bank contents and committed bank.
  logic [7:0]  m_shadow [NREGS];
  logic [63:0] m_regs;
  logic [7:0]  frame_q[$];

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_shadow[r] = 8'h00;
    m_regs = '0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      wait_clks($urandom_range(3, 5));
      spi_clk = 1'b1;
      wait_clks($urandom_range(3, 5));
      spi_clk = 1'b0;
    end
  endtask

  task automatic run_frame(input int abort_bits, input string name);
    int exp_addr[$];
    int a;
    bit inc;
    bit wrote;
    a = int'(frame_q[0][6:0]);
    inc = frame_q[0][7];
    wrote = 1'b0;
    for (int k = 1; k < frame_q.size(); k++) begin
      if (a < NREGS) begin
        m_shadow[a] = frame_q[k];
        exp_addr.push_back(a);
        wrote = 1'b1;
      end
      if (inc) a = (a + 1) % 128;
    end
    if (wrote) begin
      for (int r = 0; r < NREGS; r++) m_regs[r*8 +: 8] = m_shadow[r];
    end

    obs_addr.delete();
    commit_cycles = 0;
    busy_seen = 1'b0;

    spi_nss = 1'b0;
    wait_clks(4);
    foreach (frame_q[k]) spi_bits(frame_q[k], 8);
    if (abort_bits > 0) spi_bits(8'($urandom), abort_bits);
    wait_clks(3);
    spi_nss = 1'b1;
    wait_clks(8);

    check({name, ".nstrobe"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < obs_addr.size()) check({name, ".wr_addr"}, 64'(obs_addr[i]), 64'(exp_addr[i]));
    end
    check({name, ".commits"}, 64'(commit_cycles), wrote ? 64'd1 : 64'd0);
    check({name, ".regs_q"}, regs_q, m_regs);
    check({name, ".busy_seen"}, 64'(busy_seen), 64'd1);
    check({name, ".busy_end"}, 64'(busy), 64'd0);
    wait_clks(3);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int ab;
    int base;
    logic inc_bit;

    model_reset();
    rstn = 1'b0;
    wait_clks(3);
    check("rst.regs_q", regs_q, 64'd0);
    check("rst.commit", 64'(commit), 64'd0);
    check("rst.wr_strobe", 64'(wr_strobe), 64'd0);
    check("rst.wr_addr", 64'(wr_addr), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    rstn = 1'b1;
    wait_clks(6);

    frame_q = {8'h02, 8'hA5};               run_frame(0, "single");
    frame_q = {8'h86, 8'h11, 8'h22, 8'h33}; run_frame(0, "burst");
    frame_q = {8'h03, 8'h10, 8'h20};        run_frame(0, "repeat");
    frame_q = {8'h01, 8'h5A};               run_frame(4, "abort");
    frame_q = {8'h04};                      run_frame(0, "addr_only");
    frame_q = {8'h7F, 8'hFF};               run_frame(0, "out_of_range");
    frame_q = {8'hFF, 8'h01, 8'h02};        run_frame(0, "wrap127");

    for (int f = 0; f < 24; f++) begin
      inc_bit = 1'($urandom_range(0, 1));
      base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(120, 127)) : int'($urandom_range(0, 11));
      frame_q.delete();
      frame_q.push_back({inc_bit, 7'(base)});
      nb = $urandom_range(0, 4);
      for (int k = 0; k < nb; k++) frame_q.push_back(8'($urandom));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      run_frame(ab, "random");
    end

    // Reset in the middle of a data byte with nss still low.
    obs_addr.delete();
    spi_nss = 1'b0;
    wait_clks(4);
    spi_bits(8'h01, 8);
    spi_bits(8'h33, 4);
    rstn = 1'b0;
    wait_clks(2);
    check("midrst.regs_q", regs_q, 64'd0);
    check("midrst.commit", 64'(commit), 64'd0);
    check("midrst.wr_strobe", 64'(wr_strobe), 64'd0);
    check("midrst.wr_addr", 64'(wr_addr), 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    rstn = 1'b1;
    model_reset();
    obs_addr.delete();
    commit_cycles = 0;
    busy_seen = 1'b0;
    spi_bits(8'h3C, 4);
    spi_bits(8'h44, 8);
    wait_clks(3);
    spi_nss = 1'b1;
    wait_clks(8);
    check("midrst.nstrobe", 64'(obs_addr.size()), 64'd0);
    check("midrst.commits", 64'(commit_cycles), 64'd0);
    check("midrst.busy_seen", 64'(busy_seen), 64'd0);
    check("midrst.regs_q_after", regs_q, 64'd0);
    wait_clks(6);
    frame_q = {8'h00, 8'h77};               run_frame(0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_cfg_ctrl.md
# spi_cfg_ctrl

SPI-slave configuration controller between the board SPI pins and the synthesizer core. Synchronises the raw, asynchronous `spi_clk`/`spi_mosi`/`spi_nss` inputs into the system clock domain and decodes write-only frames (address byte, then data bytes). Data goes into a shadow register bank, which is committed atomically to the active bank that drives the synth parameters when the frame ends.

## Interface
- `NREGS`, 8: number of 8-bit configuration registers; legal range is 1..128.
- `clk`  in  1: system clock; the only clock in the block.
- `rstn`  in  1: reset, synchronous and active-low.
- `spi_clk`  in  1: raw SPI clock, asynchronous; mode 0.
- `spi_mosi`  in  1: raw SPI data, asynchronous; MSB first.
- `spi_nss`  in  1: raw SPI select, asynchronous, active-low.
- `regs_q`  out  NREGS*8: active register bank; register i occupies bits [8i+7:8i].
- `commit`  out  1: one-cycle pulse in the cycle `regs_q` takes new shadow content.
- `wr_strobe`  out  1: one-cycle pulse per in-range data byte written to the shadow bank.
- `wr_addr`  out  7: address of the current `wr_strobe`; holds its value otherwise.
- `busy`  out  1: high from frame start until commit or abort is processed.

## Operation
- **Synchronisation:** each raw input passes through a 2-FF synchroniser followed by a history flop.
  - Edges are detected as synchronised value vs. history value.
  - `spi_mosi` is read from its synchronised stage on a detected `spi_clk` rising edge.
- **FSM states:** WAIT_IDLE, IDLE, ADDR, DATA.
  - WAIT_IDLE: entered on reset. Moves to IDLE once synchronised nss = 1. A frame already in progress at reset release is ignored.
  - IDLE → ADDR: on synchronised nss falling. `busy` rises, 3-bit bit counter clears, `dirty` clears.
  - ADDR: shifts 8 bits. Address byte format: bit7 = auto-increment enable (INC), bits[6:0] = start address. After the 8th bit, latch address and INC, then → DATA.
  - DATA: shifts 8 bits per byte. On the 8th bit:
    - If address < NREGS: write shadow[address], pulse `wr_strobe`, drive `wr_addr` = address, set `dirty`.
    - If address ≥ NREGS: discard the byte, no strobe.
    - If INC = 1: address ← address+1, 7-bit wrap (127 → 0). If INC = 0, address is unchanged.
  - Any state except WAIT_IDLE: on synchronised nss rising, drop the partial byte and bit count, → IDLE.
    - If `dirty`: copy shadow bank → `regs_q` and pulse `commit`.
    - `busy` falls in the same cycle.
- **Simultaneous events:** nss rising and `spi_clk` rising detected in the same cycle → nss wins and the clock edge is ignored.
- **No-commit cases:** a frame with only an address byte, or only out-of-range writes, produces no `commit` and leaves `regs_q` unchanged.
- **Shadow persistence:** the shadow bank is not reloaded from `regs_q`. It keeps its last-written values, so partial-register frames are well defined.
- **Reset values (all cleared on `rstn` = 0 at a clk edge):**
  - `regs_q` = 0, shadow bank = 0.
  - `commit` = 0, `wr_strobe` = 0, `wr_addr` = 0, `busy` = 0.
  - Synchroniser flops = 1 for nss, 0 for the others.
  - FSM in WAIT_IDLE.
  - Reset mid-frame discards all frame progress.

## Timing
- **Capture latency:** a raw edge first captured at clk edge E0 is acted on at edge E2.
  - `wr_strobe` and the shadow write are visible after E2 for the 8th `spi_clk` rise of a data byte.
  - `commit` and `regs_q` update are visible after E2 for an nss rise.
- **SPI clock limits:** `spi_clk` high and low phases must each be ≥ 3 clk periods.
- **Frame timing:** nss setup before the first `spi_clk` rise and hold after the last rise must each be ≥ 3 clk periods.
- **Pulse widths:** `wr_strobe` and `commit` are exactly 1 cycle. At most one `wr_strobe` per 16 clk cycles under the limits above.
- **Frame gap:** minimum nss-high time between frames is 3 clk periods.

## Structure
- **Package `cd101_pkg`:**
  - `CFG_ADDR_W` = 7.
  - `CFG_INC_BIT` = 7.
  - FSM state enum {WAIT_IDLE, IDLE, ADDR, DATA}.
  - `NREGS_MAX` = 128.
- **Sub-module `sync_edge`:** 2-FF synchroniser plus history flop.
  - Outputs: `level`, `rise`, `fall`.
  - Reset value is a parameter.
  - Instantiated three times.

## Test plan
- **Single write:** reset; frame 0x02, 0xA5 → `wr_strobe` with `wr_addr` = 2; after nss rise, `commit` for 1 cycle, `regs_q[23:16]` = 0xA5, all other bits 0.
- **Burst with wrap:** NREGS = 8; frame 0x86, 0x11, 0x22, 0x33 → registers 6 = 0x11 and 7 = 0x22; 0x33 at address 8 is discarded (2 strobes); one `commit`.
- **Repeat address:** frame 0x03, 0x10, 0x20 → 2 strobes, both `wr_addr` = 3; `regs_q` register 3 = 0x20 after commit.
- **Abort mid-byte:** frame 0x01, 0x5A, then 4 bits of 0xF0, then nss rise → register 1 = 0x5A, commit once, no third strobe.
- **No-op frames:** address-only frame 0x04, and frame 0x7F, 0xFF with NREGS = 8 → no `commit`; `regs_q` unchanged; `busy` pulses for each frame.
- **Reset mid-frame:** `rstn` low during a data byte with nss still low → all outputs 0; the next bytes of that frame are ignored; after nss goes high, a new frame 0x00, 0x77 commits register 0 = 0x77.
